// File: rtl/sdio_cmd_sequencer.sv
// sdio_cmd_sequencer
//   Command-layer controller above the SDIO device PHY. Latches each decoded
//   command, tracks the card state (INIT/STBY/CMD), runs CMD52 register
//   accesses, builds R4/R5/R6/R1b response frames and starts the PHY data
//   phase for CMD53 byte-mode transfers.
//
//   Optional feature macro: SDIO_REG_TIMEOUT_EN
//     defined   -> REG_WAIT gives up after REG_TIMEOUT clocks and answers
//                  R5 with ERROR set and data 8'h00
//     undefined -> REG_WAIT waits for i_reg_ack indefinitely
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   i_cmd_stb/_crc_good_stb      new command pulse and its CRC verdict
//   i_cmd, i_cmd_arg             command index and argument
//   i_rsps_idle                  PHY command line idle
//   o_rsps_stb/o_rsps/_len       response pulse, 40-bit frame, bits-1
//   o_rsps_fail                  suppress response, PHY back to idle
//   o_reg_*/i_reg_*              CMD52 register access handshake
//   o_data_*/o_write_flag        CMD53 data-phase setup and start pulse
//   i_data_finished              data phase complete
//   o_card_state                 0 INIT, 1 STBY, 2 CMD
module sdio_cmd_sequencer #(
  parameter int          NUM_FUNCS   = 1,
  parameter logic [23:0] OCR         = 24'hFF8000,
  parameter logic [15:0] RCA_VALUE   = 16'h0001,
  parameter int          REG_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_stb,
  input  logic        i_cmd_crc_good_stb,
  input  logic [5:0]  i_cmd,
  input  logic [31:0] i_cmd_arg,
  input  logic        i_rsps_idle,
  output logic        o_rsps_stb,
  output logic [39:0] o_rsps,
  output logic [7:0]  o_rsps_len,
  output logic        o_rsps_fail,
  output logic        o_reg_req,
  output logic        o_reg_write,
  output logic [2:0]  o_reg_func,
  output logic [16:0] o_reg_addr,
  output logic [7:0]  o_reg_wdata,
  input  logic        i_reg_ack,
  input  logic [7:0]  i_reg_rdata,
  output logic        o_data_activate,
  output logic        o_write_flag,
  output logic [12:0] o_data_count,
  output logic [2:0]  o_data_func,
  output logic [16:0] o_data_addr,
  output logic        o_data_incr,
  input  logic        i_data_finished,
  output logic [1:0]  o_card_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_REG_WAIT  = 3'd2;
  localparam logic [2:0] S_RESPOND   = 3'd3;
  localparam logic [2:0] S_RSPS_WAIT = 3'd4;
  localparam logic [2:0] S_DATA      = 3'd5;
  localparam logic [2:0] S_FAIL      = 3'd6;

  localparam logic [1:0] CS_INIT = 2'd0;
  localparam logic [1:0] CS_STBY = 2'd1;
  localparam logic [1:0] CS_CMD  = 2'd2;

  // R5 flag byte: {CRC_ERR, ILLEGAL, CUR_STATE[1:0], ERROR, 0, FUNC_NUM, OUT_OF_RANGE}
  localparam logic [7:0] F_CUR_CMD = 8'h10;
  localparam logic [7:0] F_CUR_TRN = 8'h20;
  localparam logic [7:0] F_ERROR   = 8'h08;
  localparam logic [7:0] F_FUNC    = 8'h02;

  localparam logic [2:0] NF3 = 3'(NUM_FUNCS);

  function automatic logic [39:0] frame(input logic [5:0] idx, input logic [31:0] pl);
    return {1'b0, idx, pl, 1'b0};
  endfunction

  function automatic logic [39:0] r5(input logic [5:0] idx, input logic [7:0] flags,
                                     input logic [7:0] data);
    return frame(idx, {16'h0, flags, data});
  endfunction

  logic [2:0]  state_q, state_d;
  logic [1:0]  card_q, card_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic        crc_q, crc_d;
  logic [39:0] rsps_q, rsps_d;
  logic [7:0]  len_q, len_d;
  logic        pend_q, pend_d;   // valid CMD53 awaiting its data phase
  logic        act_q, act_d;
  logic        reg_write_q, reg_write_d;
  logic [2:0]  reg_func_q, reg_func_d;
  logic [16:0] reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        wr_q, wr_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  dfunc_q, dfunc_d;
  logic [16:0] daddr_q, daddr_d;
  logic        incr_q, incr_d;

`ifdef SDIO_REG_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = (REG_TIMEOUT == 0);
`endif

  always_comb begin
    state_d     = state_q;
    card_d      = card_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    crc_d       = crc_q;
    rsps_d      = rsps_q;
    len_d       = len_q;
    pend_d      = pend_q;
    act_d       = 1'b0;
    reg_write_d = reg_write_q;
    reg_func_d  = reg_func_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    dfunc_d     = dfunc_q;
    daddr_d     = daddr_q;
    incr_d      = incr_q;
`ifdef SDIO_REG_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_cmd_stb) begin
          cmd_d   = i_cmd;
          arg_d   = i_cmd_arg;
          crc_d   = i_cmd_crc_good_stb;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FAIL;
        pend_d  = 1'b0;
        len_d   = 8'd38;
`ifdef SDIO_REG_TIMEOUT_EN
        tmo_d   = '0;
`endif
        // A bad CRC fails without touching card state.
        if (crc_q) begin
          case (cmd_q)
            6'd0: card_d = CS_INIT;
            6'd3: begin
              rsps_d  = frame(cmd_q, {RCA_VALUE, 16'h0});
              card_d  = CS_STBY;
              state_d = S_RESPOND;
            end
            6'd5: begin
              rsps_d  = frame(6'h3F, {1'b1, NF3, 4'h0, OCR});
              state_d = S_RESPOND;
            end
            6'd7: begin
              if (arg_q[31:16] == RCA_VALUE && card_q != CS_INIT) begin
                // Status reports the state the card was in when CMD7 arrived.
                rsps_d  = frame(cmd_q, {19'h0, (card_q == CS_CMD) ? 4'd4 : 4'd3, 9'h0});
                card_d  = CS_CMD;
                state_d = S_RESPOND;
              end else if (card_q == CS_CMD) begin
                card_d = CS_STBY;
              end
            end
            6'd52: begin
              if (card_q == CS_CMD) begin
                if (arg_q[30:28] > NF3) begin
                  rsps_d  = r5(cmd_q, F_CUR_CMD | F_FUNC, 8'h00);
                  state_d = S_RESPOND;
                end else begin
                  reg_write_d = arg_q[31];
                  reg_func_d  = arg_q[30:28];
                  reg_addr_d  = arg_q[25:9];
                  reg_wdata_d = arg_q[7:0];
                  state_d     = S_REG_WAIT;
                end
              end
            end
            6'd53: begin
              if (card_q == CS_CMD) begin
                state_d = S_RESPOND;
                if (arg_q[27]) begin
                  rsps_d = r5(cmd_q, F_CUR_CMD | F_ERROR, 8'h00);
                end else begin
                  rsps_d  = r5(cmd_q, F_CUR_TRN, 8'h00);
                  wr_d    = arg_q[31];
                  dfunc_d = arg_q[30:28];
                  incr_d  = arg_q[26];
                  daddr_d = arg_q[25:9];
                  cnt_d   = (arg_q[8:0] == 9'd0) ? 13'd512 : {4'd0, arg_q[8:0]};
                  pend_d  = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      S_REG_WAIT: begin
        if (i_reg_ack) begin
          rsps_d  = r5(cmd_q, F_CUR_CMD, i_reg_rdata);
          state_d = S_RESPOND;
        end
`ifdef SDIO_REG_TIMEOUT_EN
        else if (tmo_q == 16'(REG_TIMEOUT - 1)) begin
          rsps_d  = r5(cmd_q, F_CUR_CMD | F_ERROR, 8'h00);
          state_d = S_RESPOND;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      S_RESPOND: state_d = S_RSPS_WAIT;
      S_RSPS_WAIT: begin
        if (i_rsps_idle) begin
          if (pend_q) begin
            state_d = S_DATA;
            act_d   = 1'b1;
            pend_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA:  if (i_data_finished) state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      card_q      <= CS_INIT;
      cmd_q       <= '0;
      arg_q       <= '0;
      crc_q       <= 1'b0;
      rsps_q      <= '0;
      len_q       <= '0;
      pend_q      <= 1'b0;
      act_q       <= 1'b0;
      reg_write_q <= 1'b0;
      reg_func_q  <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      dfunc_q     <= '0;
      daddr_q     <= '0;
      incr_q      <= 1'b0;
`ifdef SDIO_REG_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      card_q      <= card_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      crc_q       <= crc_d;
      rsps_q      <= rsps_d;
      len_q       <= len_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      reg_write_q <= reg_write_d;
      reg_func_q  <= reg_func_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      dfunc_q     <= dfunc_d;
      daddr_q     <= daddr_d;
      incr_q      <= incr_d;
`ifdef SDIO_REG_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Strobes come straight from state so a reset can never leave one pending.
  assign o_rsps_stb      = (state_q == S_RESPOND);
  assign o_rsps_fail     = (state_q == S_FAIL);
  assign o_reg_req       = (state_q == S_REG_WAIT);
  assign o_data_activate = act_q;
  assign o_rsps          = rsps_q;
  assign o_rsps_len      = len_q;
  assign o_reg_write     = reg_write_q;
  assign o_reg_func      = reg_func_q;
  assign o_reg_addr      = reg_addr_q;
  assign o_reg_wdata     = reg_wdata_q;
  assign o_write_flag    = wr_q;
  assign o_data_count    = cnt_q;
  assign o_data_func     = dfunc_q;
  assign o_data_addr     = daddr_q;
  assign o_data_incr     = incr_q;
  assign o_card_state    = card_q;

endmodule

// File: tb/tb_sdio_cmd_sequencer.sv
// Bench for sdio_cmd_sequencer: a command-level model predicts each
// command's outcome; a per-cycle loop compares DUT outputs against it.
module tb_sdio_cmd_sequencer;
  localparam int          NUM_FUNCS = 1;
  localparam logic [15:0] RCA       = 16'h0001;
  localparam logic [23:0] OCR       = 24'hFF8000;
  localparam int          TMO       = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_cmd_stb, i_cmd_crc_good_stb, i_rsps_idle;
  logic [5:0]  i_cmd;
  logic [31:0] i_cmd_arg;
  logic        o_rsps_stb, o_rsps_fail, o_reg_req, o_reg_write, i_reg_ack;
  logic [39:0] o_rsps;
  logic [7:0]  o_rsps_len, o_reg_wdata, i_reg_rdata;
  logic [2:0]  o_reg_func, o_data_func;
  logic [16:0] o_reg_addr, o_data_addr;
  logic        o_data_activate, o_write_flag, o_data_incr, i_data_finished;
  logic [12:0] o_data_count;
  logic [1:0]  o_card_state;

  sdio_cmd_sequencer #(.NUM_FUNCS(NUM_FUNCS), .OCR(OCR), .RCA_VALUE(RCA), .REG_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .i_cmd_stb(i_cmd_stb), .i_cmd_crc_good_stb(i_cmd_crc_good_stb),
    .i_cmd(i_cmd), .i_cmd_arg(i_cmd_arg), .i_rsps_idle(i_rsps_idle),
    .o_rsps_stb(o_rsps_stb), .o_rsps(o_rsps), .o_rsps_len(o_rsps_len), .o_rsps_fail(o_rsps_fail),
    .o_reg_req(o_reg_req), .o_reg_write(o_reg_write), .o_reg_func(o_reg_func),
    .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata), .i_reg_ack(i_reg_ack),
    .i_reg_rdata(i_reg_rdata), .o_data_activate(o_data_activate), .o_write_flag(o_write_flag),
    .o_data_count(o_data_count), .o_data_func(o_data_func), .o_data_addr(o_data_addr),
    .o_data_incr(o_data_incr), .i_data_finished(i_data_finished), .o_card_state(o_card_state)
  );

  int checks = 0;
  int errors = 0;

  // model state / predictions
  int          mcard;
  bit          m_stb, m_fail, m_act;
  int          m_req, m_cnt;
  logic [39:0] m_frame, last_frame;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] mk(input int idx, input logic [31:0] pl);
    logic [39:0] f;
    f = (40'(idx) << 33) | (40'(pl) << 1);
    return f;
  endfunction

  // Outcome of one command from the card rules; ack_after==0 means never acked.
  task automatic model(input logic [5:0] idx, input logic [31:0] arg, input bit crc,
                       input int ack_after, input logic [7:0] rdata);
    logic [7:0]  fl, dt;
    logic [31:0] pl;
    m_stb = 0; m_fail = 0; m_act = 0; m_req = 0; m_cnt = 0; m_frame = '0;
    if (!crc) m_fail = 1;
    else if (idx == 0) begin m_fail = 1; mcard = 0; end
    else if (idx == 3) begin m_stb = 1; m_frame = mk(3, {RCA, 16'h0}); mcard = 1; end
    else if (idx == 5) begin
      pl = 32'h8000_0000 + 32'(NUM_FUNCS) * 32'h1000_0000 + {8'h0, OCR};
      m_stb = 1; m_frame = mk(63, pl);
    end else if (idx == 7) begin
      if (arg[31:16] == RCA && mcard != 0) begin
        pl = ((mcard == 2) ? 32'd4 : 32'd3) * 32'd512;
        m_stb = 1; m_frame = mk(7, pl); mcard = 2;
      end else begin
        m_fail = 1; if (mcard == 2) mcard = 1;
      end
    end else if (idx == 52 || idx == 53) begin
      if (mcard != 2) m_fail = 1;
      else begin
        m_stb = 1; fl = 8'h10; dt = 8'h00;
        if (idx == 52) begin
          if (int'(arg[30:28]) > NUM_FUNCS) fl = fl | 8'h02;
          else if (ack_after > 0) begin m_req = ack_after; dt = rdata; end
          else begin m_req = TMO; fl = fl | 8'h08; end
        end else if (arg[27]) fl = fl | 8'h08;
        else begin
          fl = 8'h20; m_act = 1;
          m_cnt = (arg[8:0] == 0) ? 512 : int'(arg[8:0]);
        end
        m_frame = mk(int'(idx), {16'h0, fl, dt});
      end
    end else m_fail = 1;
  endtask

  task automatic run(input string nm, input logic [5:0] idx, input logic [31:0] arg, input bit crc,
                     input int ack_after, input logic [7:0] rdata, input int idle_dly, input bit spur);
    int nstb, nfail, nreq, nact, stb_at, act_at;
    nstb = 0; nfail = 0; nreq = 0; nact = 0; stb_at = -100; act_at = -100;
    model(idx, arg, crc, ack_after, rdata);
    @(negedge clk);
    i_cmd = idx; i_cmd_arg = arg; i_cmd_stb = 1; i_cmd_crc_good_stb = crc; i_rsps_idle = 0;
    i_reg_rdata = rdata;
    @(negedge clk);
    i_cmd_stb = 0; i_cmd_crc_good_stb = 0;
    for (int c = 0; c < 30; c++) begin
      if (o_rsps_stb) begin
        nstb++; stb_at = c; last_frame = o_rsps;
        chk({nm, " frame"}, o_rsps, m_frame);
        chk({nm, " len"}, o_rsps_len, 38);
        chk({nm, " card@rsp"}, o_card_state, mcard);
      end
      if (o_rsps_fail) begin
        nfail++;
        chk({nm, " card@fail"}, o_card_state, mcard);
      end
      if (o_reg_req) begin
        nreq++;
        if (nreq == 1) begin
          chk({nm, " reg_write"}, o_reg_write, arg[31]);
          chk({nm, " reg_func"}, o_reg_func, arg[30:28]);
          chk({nm, " reg_addr"}, o_reg_addr, arg[25:9]);
          chk({nm, " reg_wdata"}, o_reg_wdata, arg[7:0]);
        end
      end
      if (o_data_activate) begin
        nact++; act_at = c;
        chk({nm, " act_timing"}, act_at, stb_at + ((idle_dly > 1) ? idle_dly : 1) + 1);
        chk({nm, " count"}, o_data_count, m_cnt);
        chk({nm, " wflag"}, o_write_flag, arg[31]);
        chk({nm, " dfunc"}, o_data_func, arg[30:28]);
        chk({nm, " daddr"}, o_data_addr, arg[25:9]);
        chk({nm, " incr"}, o_data_incr, arg[26]);
      end
      i_reg_ack       = o_reg_req && ack_after > 0 && nreq == ack_after;
      i_rsps_idle     = (nstb > 0) && (c >= stb_at + idle_dly);
      i_data_finished = (nact > 0) && (c == act_at + 3);
      i_cmd_stb       = spur && (c == 1);
      i_cmd_crc_good_stb = i_cmd_stb;
      if (i_cmd_stb) i_cmd = 6'd5;
      @(negedge clk);
    end
    i_reg_ack = 0; i_data_finished = 0; i_cmd_stb = 0; i_cmd_crc_good_stb = 0; i_rsps_idle = 1;
    chk({nm, " n_rsps_stb"}, nstb, m_stb ? 1 : 0);
    chk({nm, " n_fail"}, nfail, m_fail ? 1 : 0);
    chk({nm, " req_cycles"}, nreq, m_req);
    chk({nm, " n_activate"}, nact, m_act ? 1 : 0);
    chk({nm, " card_end"}, o_card_state, mcard);
  endtask

  initial begin
    rst = 1; i_cmd_stb = 0; i_cmd_crc_good_stb = 0; i_cmd = 0; i_cmd_arg = 0;
    i_rsps_idle = 1; i_reg_ack = 0; i_reg_rdata = 0; i_data_finished = 0;
    mcard = 0; last_frame = '0;
    repeat (3) @(negedge clk);
    chk("rst rsps_stb", o_rsps_stb, 0);
    chk("rst rsps_fail", o_rsps_fail, 0);
    chk("rst rsps", o_rsps, 0);
    chk("rst len", o_rsps_len, 0);
    chk("rst reg_req", o_reg_req, 0);
    chk("rst activate", o_data_activate, 0);
    chk("rst count", o_data_count, 0);
    chk("rst card", o_card_state, 0);
    rst = 0;

    run("cmd52_init", 6'd52, 32'h0000_0E00, 1, 1, 8'h00, 1, 0);
    run("cmd5", 6'd5, 32'h0, 1, 0, 8'h00, 1, 0);
    chk("pin r4", last_frame, 40'h7F21FF0000);
    run("cmd3_badcrc", 6'd3, 32'h0, 0, 0, 8'h00, 1, 0);
    run("cmd7_init", 6'd7, 32'h0001_0000, 1, 0, 8'h00, 1, 0);
    run("cmd3", 6'd3, 32'h0, 1, 0, 8'h00, 1, 0);
    chk("pin r6", last_frame, 40'h0600020000);
    chk("pin stby", o_card_state, 2'd1);
    run("cmd7_badrca", 6'd7, 32'h0002_0000, 1, 0, 8'h00, 1, 0);
    run("cmd7", 6'd7, 32'h0001_0000, 1, 0, 8'h00, 1, 0);
    chk("pin r1b", last_frame, 40'h0E00000C00);
    chk("pin cmdstate", o_card_state, 2'd2);
    run("cmd7_again", 6'd7, 32'h0001_0000, 1, 0, 8'h00, 0, 0);
    run("cmd52_rd", 6'd52, 32'h0000_0E00, 1, 5, 8'hA5, 1, 1);
    chk("pin r5 rd", last_frame, 40'h680000214A);
    run("cmd52_wr", 6'd52, {1'b1, 3'd1, 2'b0, 17'h01234, 1'b0, 8'h5A}, 1, 1, 8'h5A, 2, 0);
    run("cmd52_fn", 6'd52, {1'b0, 3'd3, 2'b0, 17'h00010, 1'b0, 8'h00}, 1, 1, 8'h11, 1, 0);
    run("cmd53_wr", 6'd53, 32'h9002_0000, 1, 0, 8'h00, 3, 0);
    chk("pin r5 trn", last_frame, 40'h6A00004000);
    run("cmd53_rd", 6'd53, {1'b0, 3'd1, 1'b0, 1'b1, 17'h1ABCD, 9'd5}, 1, 0, 8'h00, 2, 0);
    run("cmd53_blk", 6'd53, {1'b1, 3'd1, 1'b1, 1'b0, 17'h00100, 9'd8}, 1, 0, 8'h00, 1, 0);
    run("cmd_bad", 6'd9, 32'h0, 1, 0, 8'h00, 1, 0);
`ifdef SDIO_REG_TIMEOUT_EN
    run("cmd52_tmo", 6'd52, 32'h0000_0600, 1, 0, 8'h77, 1, 0);
`endif
    run("cmd7_drop", 6'd7, 32'h0005_0000, 1, 0, 8'h00, 1, 0);
    run("cmd0", 6'd0, 32'h0, 1, 0, 8'h00, 1, 0);

    // reset in the middle of a register access
    run("re_cmd3", 6'd3, 32'h0, 1, 0, 8'h00, 1, 0);
    run("re_cmd7", 6'd7, 32'h0001_0000, 1, 0, 8'h00, 1, 0);
    @(negedge clk);
    i_cmd = 6'd52; i_cmd_arg = 32'h0000_0E00; i_cmd_stb = 1; i_cmd_crc_good_stb = 1;
    @(negedge clk);
    i_cmd_stb = 0; i_cmd_crc_good_stb = 0;
    repeat (2) @(negedge clk);
    chk("midrst req before", o_reg_req, 1);
    rst = 1;
    @(negedge clk);
    rst = 0; i_reg_ack = 1; mcard = 0;
    chk("midrst req", o_reg_req, 0);
    chk("midrst card", o_card_state, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_reg_ack = 0;
      chk("midrst no stb", {o_rsps_stb, o_rsps_fail, o_data_activate}, 3'b000);
    end
    run("post_rst_cmd5", 6'd5, 32'h0, 1, 0, 8'h00, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
